// File: rtl/bitcoin_pkg.sv
// Shared definitions for the bitcoin hashing core and its post-processing stages.
package bitcoin_pkg;

    localparam int unsigned DEFAULT_NUM_NONCES = 16;
    localparam int unsigned HASH_W             = 32;
    localparam int unsigned ADDR_W             = 16;
    localparam int unsigned INFO_FOUND_BIT     = 31;
    localparam int unsigned INFO_INDEX_W       = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WR_HASH = 2'd2,
        WR_INFO = 2'd3
    } state_t;

    // Second result word: found flag in the top bit, winning index in the low bits.
    function automatic logic [HASH_W-1:0] pack_info(input logic found,
                                                    input logic [INFO_INDEX_W-1:0] index);
        logic [HASH_W-1:0] word;
        word                      = '0;
        word[INFO_FOUND_BIT]      = found;
        word[INFO_INDEX_W-1:0]    = index;
        return word;
    endfunction

endpackage

// File: rtl/bitcoin_nonce_select.sv
// Scans NUM_NONCES hash words in memory, keeps the smallest, compares it with
// the difficulty target and writes a {best_hash, info} record back to memory.
module bitcoin_nonce_select
    import bitcoin_pkg::*;
#(
    parameter int unsigned NUM_NONCES = DEFAULT_NUM_NONCES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       hash_out_addr,
    input  logic [ADDR_W-1:0]       result_addr,
    input  logic [HASH_W-1:0]       target,
    output logic                    done,
    output logic                    found,
    output logic [INFO_INDEX_W-1:0] best_nonce,
    output logic [HASH_W-1:0]       best_hash,
    output logic                    mem_clk,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       memory_addr,
    output logic [HASH_W-1:0]       memory_write_data,
    input  logic [HASH_W-1:0]       memory_read_data
);

    // Counts READ cycles; must hold values up to NUM_NONCES (256 max).
    localparam int unsigned CNT_W = 9;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        cycle_cnt;
    logic [ADDR_W-1:0]       result_q;
    logic [HASH_W-1:0]       target_q;

    logic                    issue_c;
    logic                    capture_c;
    logic                    last_c;
    logic                    take_c;
    logic [INFO_INDEX_W-1:0] cap_index_c;
    logic [HASH_W-1:0]       best_hash_next_c;
    logic [INFO_INDEX_W-1:0] best_nonce_next_c;
    logic                    found_next_c;

    assign mem_clk = clk;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = READ;
            READ:    if (last_c) state_next = WR_HASH;
            WR_HASH: state_next = WR_INFO;
            WR_INFO: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Scan control and running-minimum select. Before READ edge k the counter
    // holds k-1: addresses are issued for k <= N-1, word k-2 is captured for k >= 2.
    always_comb begin
        issue_c           = 1'b0;
        capture_c         = 1'b0;
        last_c            = 1'b0;
        cap_index_c       = INFO_INDEX_W'(cycle_cnt - CNT_W'(1));
        if (state == READ) begin
            issue_c   = (cycle_cnt < CNT_W'(NUM_NONCES - 1));
            capture_c = (cycle_cnt != '0);
            last_c    = (cycle_cnt == CNT_W'(NUM_NONCES));
        end
        take_c            = capture_c &&
                            ((cap_index_c == '0) || (memory_read_data < best_hash));
        best_hash_next_c  = take_c ? memory_read_data : best_hash;
        best_nonce_next_c = take_c ? cap_index_c : best_nonce;
        found_next_c      = (best_hash_next_c < target_q);
    end

    // Datapath and registered memory-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done              <= 1'b1;
            found             <= 1'b0;
            best_nonce        <= '0;
            best_hash         <= '0;
            mem_we            <= 1'b0;
            memory_addr       <= '0;
            memory_write_data <= '0;
            cycle_cnt         <= '0;
            result_q          <= '0;
            target_q          <= '0;
        end else begin
            done <= (state_next == IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        result_q    <= result_addr;
                        target_q    <= target;
                        memory_addr <= hash_out_addr;
                        cycle_cnt   <= '0;
                        found       <= 1'b0;
                        best_nonce  <= '0;
                        best_hash   <= '0;
                        mem_we      <= 1'b0;
                    end
                end
                READ: begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (issue_c) begin
                        memory_addr <= memory_addr + ADDR_W'(1);
                    end
                    if (capture_c) begin
                        best_hash  <= best_hash_next_c;
                        best_nonce <= best_nonce_next_c;
                        found      <= found_next_c;
                    end
                    if (last_c) begin
                        memory_addr       <= result_q;
                        mem_we            <= 1'b1;
                        memory_write_data <= best_hash_next_c;
                    end
                end
                WR_HASH: begin
                    memory_addr       <= result_q + ADDR_W'(1);
                    memory_write_data <= pack_info(found, best_nonce);
                end
                WR_INFO: begin
                    mem_we <= 1'b0;
                end
                default: begin
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitcoin_nonce_select.sv
// Randomized and directed checks of bitcoin_nonce_select against a simple
// minimum-search reference model and a synchronous single-port memory model.
module tb_bitcoin_nonce_select;

    localparam int unsigned N = 16;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] hash_out_addr;
    logic [15:0] result_addr;
    logic [31:0] target;
    logic        done;
    logic        found;
    logic [7:0]  best_nonce;
    logic [31:0] best_hash;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] memory_addr;
    logic [31:0] memory_write_data;
    logic [31:0] memory_read_data;

    logic [31:0] mem [65536];
    logic [31:0] words [N];
    logic [15:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    bitcoin_nonce_select #(.NUM_NONCES(N)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .hash_out_addr     (hash_out_addr),
        .result_addr       (result_addr),
        .target            (target),
        .done              (done),
        .found             (found),
        .best_nonce        (best_nonce),
        .best_hash         (best_hash),
        .mem_clk           (mem_clk),
        .mem_we            (mem_we),
        .memory_addr       (memory_addr),
        .memory_write_data (memory_write_data),
        .memory_read_data  (memory_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory: read returns the old contents.
    always @(posedge clk) begin
        memory_read_data <= mem[memory_addr];
        if (mem_we) begin
            mem[memory_addr] = memory_write_data;
            wr_addr_q.push_back(memory_addr);
            wr_data_q.push_back(memory_write_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: smallest word, lowest index on ties, strict compare with target.
    task automatic model(input logic [31:0] tgt, output logic [31:0] m_hash,
                         output logic [7:0] m_idx, output logic m_found);
        m_hash = words[0];
        m_idx  = 8'd0;
        for (int i = 1; i < int'(N); i++) begin
            if (words[i] < m_hash) begin
                m_hash = words[i];
                m_idx  = 8'(i);
            end
        end
        m_found = (m_hash < tgt);
    endtask

    task automatic preload(input logic [15:0] base);
        for (int i = 0; i < int'(N); i++) mem[16'(base + 16'(i))] = words[i];
    endtask

    // One complete scan; pulse_at > 0 raises start for one cycle mid-scan.
    task automatic run_scan(input string tag, input logic [15:0] base, input logic [15:0] res,
                            input logic [31:0] tgt, input int pulse_at);
        logic [31:0] m_hash;
        logic [7:0]  m_idx;
        logic        m_found;
        logic [31:0] m_info;
        int          cycles;
        preload(base);
        model(tgt, m_hash, m_idx, m_found);
        m_info = m_found ? (32'h8000_0000 | 32'(m_idx)) : 32'(m_idx);
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk);
        hash_out_addr = base;
        result_addr   = res;
        target        = tgt;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " done_fall"}, 32'(done), 32'd0);
        cycles = 0;
        while (!done && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            start = (pulse_at > 0 && cycles == pulse_at);
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(cycles), 32'(N + 3));
        check({tag, " best_hash"}, best_hash, m_hash);
        check({tag, " best_nonce"}, 32'(best_nonce), 32'(m_idx));
        check({tag, " found"}, 32'(found), 32'(m_found));
        check({tag, " n_writes"}, 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check({tag, " wr0_addr"}, 32'(wr_addr_q[0]), 32'(res));
            check({tag, " wr1_addr"}, 32'(wr_addr_q[1]), 32'(16'(res + 16'd1)));
        end
        check({tag, " mem_hash"}, mem[res], m_hash);
        check({tag, " mem_info"}, mem[16'(res + 16'd1)], m_info);
    endtask

    initial begin
        int cycles;
        logic d19, d20, d39;
        reset = 1'b1;
        start = 1'b0;
        hash_out_addr = '0;
        result_addr   = '0;
        target        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst done", 32'(done), 32'd1);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst addr", 32'(memory_addr), 32'd0);
        check("rst wdata", memory_write_data, 32'd0);
        check("rst found", 32'(found), 32'd0);
        check("rst nonce", 32'(best_nonce), 32'd0);
        check("rst hash", best_hash, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Strictly decreasing words: last index wins, nothing below target.
        for (int i = 0; i < int'(N); i++) words[i] = 32'h9000_0000 - 32'(i);
        run_scan("desc", 16'h0100, 16'h0200, 32'h8000_0000, 0);
        check("desc info_const", mem[16'h0201], 32'h0000_000F);

        // Single small word.
        for (int i = 0; i < int'(N); i++) words[i] = 32'hFFFF_FFFF;
        words[5] = 32'h0000_1234;
        run_scan("one", 16'h0300, 16'h0400, 32'h0001_0000, 0);
        check("one info_const", mem[16'h0401], 32'h8000_0005);

        // Tie keeps the lower index.
        for (int i = 0; i < int'(N); i++) words[i] = 32'h0100_0000 + 32'(i);
        words[3] = 32'h0000_0010;
        words[9] = 32'h0000_0010;
        run_scan("tie", 16'h0500, 16'h0600, 32'h0000_0100, 0);

        // Address wrap through 0xFFFF.
        for (int i = 0; i < int'(N); i++) words[i] = 32'h5000_0000 ^ 32'(i * 7919);
        words[12] = 32'h0000_0042;
        run_scan("wrap", 16'hFFF8, 16'h0700, 32'h0000_0042, 0);

        // Reset mid-scan abandons the scan with no writes.
        for (int i = 0; i < int'(N); i++) words[i] = 32'h0000_1000 + 32'(i);
        preload(16'h0800);
        mem[16'h0900] = 32'hDEAD_BEEF;
        mem[16'h0901] = 32'hCAFE_F00D;
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk);
        hash_out_addr = 16'h0800;
        result_addr   = 16'h0900;
        target        = 32'hFFFF_FFFF;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst done", 32'(done), 32'd1);
        check("mid_rst mem_we", 32'(mem_we), 32'd0);
        check("mid_rst hash", best_hash, 32'd0);
        check("mid_rst nonce", 32'(best_nonce), 32'd0);
        check("mid_rst found", 32'(found), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("mid_rst idle", 32'(done), 32'd1);
        check("mid_rst n_writes", 32'(wr_addr_q.size()), 32'd0);
        check("mid_rst rec0", mem[16'h0900], 32'hDEAD_BEEF);
        check("mid_rst rec1", mem[16'h0901], 32'hCAFE_F00D);
        run_scan("after_rst", 16'h0800, 16'h0900, 32'hFFFF_FFFF, 0);

        // Start pulse during READ is ignored; minimum equal to target is not found.
        for (int i = 0; i < int'(N); i++) words[i] = 32'h2000_0000 + 32'(i * 3);
        words[7] = 32'h0123_4567;
        run_scan("pulse_eq", 16'h0A00, 16'h0B00, 32'h0123_4567, 3);

        // Randomized scans, some with heavy ties and targets near the minimum.
        for (int t = 0; t < 8; t++) begin
            logic [31:0] mh;
            logic [7:0]  mi;
            logic        mf;
            logic [31:0] tgt;
            for (int i = 0; i < int'(N); i++)
                words[i] = (t % 2 == 0) ? $urandom : 32'($urandom_range(0, 7));
            model(32'd0, mh, mi, mf);
            case (t % 3)
                0:       tgt = $urandom;
                1:       tgt = mh;
                default: tgt = mh + 32'd1;
            endcase
            run_scan($sformatf("rand%0d", t), 16'($urandom_range(0, 16'hFFFF)),
                     16'h0C00 + 16'(t * 4), tgt, 0);
        end

        // Start held high: done is high for exactly one cycle between scans.
        for (int i = 0; i < int'(N); i++) words[i] = 32'h7000_0000 - 32'(i * 5);
        preload(16'h0D00);
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk);
        hash_out_addr = 16'h0D00;
        result_addr   = 16'h0E00;
        target        = 32'h8000_0000;
        start         = 1'b1;
        @(posedge clk);
        #1;
        d19 = 1'b0;
        d20 = 1'b1;
        d39 = 1'b0;
        for (cycles = 1; cycles <= 39; cycles++) begin
            @(posedge clk);
            #1;
            if (cycles == 19) d19 = done;
            if (cycles == 20) d20 = done;
            if (cycles == 39) d39 = done;
        end
        start = 1'b0;
        check("hold done19", 32'(d19), 32'd1);
        check("hold done20", 32'(d20), 32'd0);
        check("hold done39", 32'(d39), 32'd1);
        check("hold n_writes", 32'(wr_addr_q.size()), 32'd4);
        check("hold info", mem[16'h0E01], 32'h8000_000F);
        @(posedge clk);
        #1;
        check("hold idle", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bitcoin_nonce_select.md
# bitcoin_nonce_select

Post-processing stage downstream of the bitcoin hashing core. Once the core has written one H0 word per nonce to memory at `hash_out_addr`, this block scans those `NUM_NONCES` words and selects the smallest one. It compares that minimum against a 32-bit difficulty target and writes a two-word result record back through the same single-port memory interface.

## Interface
- `NUM_NONCES`, 16: number of consecutive hash words to scan; legal range 1..256.
- `clk` input 1: sole clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `start` input 1: begin a scan; sampled only in IDLE.
- `hash_out_addr` input 16: base address of the hash words; sampled at start.
- `result_addr` input 16: base address of the 2-word result record; sampled at start.
- `target` input 32: difficulty threshold; sampled at start.
- `done` output 1: high exactly while in IDLE.
- `found` output 1: best hash < target (unsigned, strict).
- `best_nonce` output 8: index (0-based) of the minimum hash word.
- `best_hash` output 32: minimum hash word.
- `mem_clk` output 1: equals `clk`.
- `mem_we` output 1: registered write enable.
- `memory_addr` output 16: registered address.
- `memory_write_data` output 32: registered write data.
- `memory_read_data` input 32: synchronous memory read port.

## Operation
- States: IDLE, READ, WR_HASH, WR_INFO.
- IDLE: if `start`, latch `hash_out_addr`, `result_addr`, `target`; set `memory_addr` to `hash_out_addr`; clear issue and capture counters; go to READ. Otherwise hold. `start` outside IDLE is ignored.
- READ:
  - Increments `memory_addr` each cycle until `NUM_NONCES` addresses have been issued.
  - Capture begins one cycle after the first issue. Word i is captured on the cycle after its address was sampled by the memory.
  - On each capture, if i==0 or word < best (unsigned, strict), set best_hash to the word and best_nonce to i.
  - Ties keep the lower index.
- After word `NUM_NONCES`-1 is captured, go to WR_HASH. In the same edge, register `memory_addr`=result_addr, `mem_we`=1, and `memory_write_data` = final best_hash, including the last word's comparison (use the combinational next-best value).
- WR_HASH: register `memory_addr`=result_addr+1 and `memory_write_data`={found, 23'b0, best_nonce}. `found` is computed from the final best_hash vs latched target. Go to WR_INFO.
- WR_INFO: `mem_we`<=0; go to IDLE.
- Address arithmetic is 16-bit and wraps modulo 2^16 (0xFFFF+1 = 0x0000).
- `found`, `best_nonce`, `best_hash`:
  - update as the scan proceeds;
  - are final and held stable from the WR_HASH entry edge until the next accepted `start`;
  - are cleared at `start` acceptance.
- Reset, any state: state=IDLE, `done`=1, `mem_we`=0, `memory_addr`=0, `memory_write_data`=0, `found`=0, `best_nonce`=0, `best_hash`=0. A scan interrupted by reset is abandoned with no further writes.

## Timing
- Edge 0 = edge on which `start` is accepted; `done` falls after edge 0.
- Address for word i is registered at edge i and sampled by memory at edge i+1. Data is captured at edge i+2.
- Last capture at edge N+1 (N=`NUM_NONCES`); WR_HASH entered at the same edge.
- Memory commits the hash word at edge N+2 and the info word at edge N+3.
- IDLE and `done`=1 after edge N+3. Total 19 cycles for N=16; 4 cycles for N=1.
- `start` held high continuously restarts a scan on the first cycle back in IDLE, so `done` is high for exactly one cycle between scans.

## Structure
- Shared package `bitcoin_pkg`:
  - state enum;
  - `NUM_NONCES` default;
  - `INFO_FOUND_BIT`=31;
  - `INFO_INDEX_W`=8.
  The hashing core imports the same `NUM_NONCES`.
- No sub-module: the compare/select is a single unsigned comparator inline in the datapath.

## Test plan
- Words 0x9000_0000 − i for i=0..15, target 0x8000_0000 → best_hash=0x8FFF_FFF1, best_nonce=15, found=0. Memory[result_addr]=0x8FFF_FFF1, [+1]=0x0000_000F. `done` returns at start edge + 19.
- All words 0xFFFF_FFFF except word 5=0x0000_1234, target 0x0001_0000 → best_nonce=5, found=1, info word 0x8000_0005.
- Words 3 and 9 both 0x0000_0010, others larger → best_nonce=3 (tie keeps lower index).
- hash_out_addr=0xFFF8, N=16 → reads 0xFFF8..0xFFFF then 0x0000..0x0007 (wrap); result correct.
- Assert `reset` at start edge + 8 → next cycle: `mem_we`=0, `done`=1, outputs zero, result record untouched. A fresh start then completes normally.
- `start` pulsed during READ → ignored; a single result write pair; timing unchanged. Also: word equal to target → found=0.
